// File: rtl/befehl_laden_pkg.sv
// befehl_laden_pkg: shared types and constants for the instruction-fetch stage.
//   zustand_t           fetch FSM state encoding (IDLE, WAIT, DONE)
//   NOP_BEFEHL_DEFAULT  instruction word delivered after an abandoned fetch
//   ZAEHLER_BREITE      width of the fetch timeout counter
//   WORT_BREITE         instruction / address word width
package befehl_laden_pkg;

  localparam int unsigned WORT_BREITE    = 32;
  localparam int unsigned ZAEHLER_BREITE = 16;

  localparam logic [WORT_BREITE-1:0] NOP_BEFEHL_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } zustand_t;

endpackage

// File: rtl/befehl_laden_zeitueberwachung.sv
// zeitueberwachung: clearable up-counter with a terminal-count flag, used to
// bound how long a fetch may wait for instruction memory.
// Ports:
//   Clock       rising-edge clock
//   Reset       asynchronous active-low reset (counter to 0)
//   Loeschen    synchronous clear, has priority over Zaehlen
//   Zaehlen     increment enable
//   Endstand_c  high while the count equals ENDWERT (decoded from the counter only)
module zeitueberwachung
  import befehl_laden_pkg::*;
#(
  parameter int unsigned ENDWERT = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Loeschen,
  input  logic Zaehlen,
  output logic Endstand_c
);

  logic [ZAEHLER_BREITE-1:0] zaehlerStand;

  // Counter register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zaehlerStand <= '0;
    end else if (Loeschen) begin
      zaehlerStand <= '0;
    end else if (Zaehlen) begin
      zaehlerStand <= zaehlerStand + ZAEHLER_BREITE'(1);
    end
  end

  assign Endstand_c = (zaehlerStand == ZAEHLER_BREITE'(ENDWERT));

endmodule

// File: rtl/befehl_laden.sv
// befehl_laden: instruction-fetch stage. On a fetch request it reads one word
// from instruction memory at PC over a request/ready bus, latches it into
// Befehl and pulses BefehlGeladen for one cycle.
// Optional feature macro: BEFEHL_TIMEOUT_EN (abandon a fetch after
// TIMEOUT_ZYKLEN wait cycles, deliver NOP_BEFEHL and set the sticky Fehler).
// Ports:
//   Clock             rising-edge clock
//   Reset             asynchronous active-low reset
//   LoadBefehlSignal  fetch request level from the control FSM
//   PC                byte address to fetch (sampled on IDLE->WAIT only)
//   SpeicherDaten     memory read data
//   SpeicherBereit    memory ready, data valid in the same cycle
//   SpeicherAdresse   registered memory address
//   SpeicherLesen     memory read request (high throughout WAIT)
//   Befehl            latched instruction word
//   BefehlGeladen     one-cycle completion pulse
//   Fehler            sticky timeout flag (constant 0 without the timeout feature)
module befehl_laden
  import befehl_laden_pkg::*;
#(
  parameter int unsigned            TIMEOUT_ZYKLEN = 255,
  parameter logic [WORT_BREITE-1:0] NOP_BEFEHL     = NOP_BEFEHL_DEFAULT
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   LoadBefehlSignal,
  input  logic [WORT_BREITE-1:0] PC,
  input  logic [WORT_BREITE-1:0] SpeicherDaten,
  input  logic                   SpeicherBereit,
  output logic [WORT_BREITE-1:0] SpeicherAdresse,
  output logic                   SpeicherLesen,
  output logic [WORT_BREITE-1:0] Befehl,
  output logic                   BefehlGeladen,
  output logic                   Fehler
);

  zustand_t zustand;
  logic     zeitAbgelaufen;

  // Elaboration-time guard on the timeout parameter range
  if ((TIMEOUT_ZYKLEN == 0) || (TIMEOUT_ZYKLEN > 65535)) begin : g_parameterPruefung
    $error("befehl_laden: TIMEOUT_ZYKLEN out of range 1..65535");
  end

`ifdef BEFEHL_TIMEOUT_EN
  logic zaehlerLoeschen;
  logic zaehlerZaehlen;

  // Counter restarts on WAIT entry and counts WAIT cycles without ready
  assign zaehlerLoeschen = (zustand == IDLE) && LoadBefehlSignal;
  assign zaehlerZaehlen  = (zustand == WAIT) && !SpeicherBereit;

  zeitueberwachung #(
    .ENDWERT (TIMEOUT_ZYKLEN)
  ) u_zeitueberwachung (
    .Clock      (Clock),
    .Reset      (Reset),
    .Loeschen   (zaehlerLoeschen),
    .Zaehlen    (zaehlerZaehlen),
    .Endstand_c (zeitAbgelaufen)
  );

  // Sticky timeout flag; ready in the terminal cycle suppresses it
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Fehler <= 1'b0;
    end else if ((zustand == WAIT) && !SpeicherBereit && zeitAbgelaufen) begin
      Fehler <= 1'b1;
    end
  end
`else
  assign zeitAbgelaufen = 1'b0;
  assign Fehler         = 1'b0;
`endif

  // Fetch FSM with registered bus and completion outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand         <= IDLE;
      SpeicherAdresse <= '0;
      SpeicherLesen   <= 1'b0;
      Befehl          <= '0;
      BefehlGeladen   <= 1'b0;
    end else begin
      case (zustand)
        IDLE: begin
          BefehlGeladen <= 1'b0;
          if (LoadBefehlSignal) begin
            SpeicherAdresse <= PC;
            SpeicherLesen   <= 1'b1;
            zustand         <= WAIT;
          end
        end
        WAIT: begin
          // The read is never aborted by the request dropping; only ready or timeout end it
          if (SpeicherBereit) begin
            Befehl        <= SpeicherDaten;
            SpeicherLesen <= 1'b0;
            BefehlGeladen <= 1'b1;
            zustand       <= DONE;
          end else if (zeitAbgelaufen) begin
            Befehl        <= NOP_BEFEHL;
            SpeicherLesen <= 1'b0;
            BefehlGeladen <= 1'b1;
            zustand       <= DONE;
          end
        end
        DONE: begin
          BefehlGeladen <= 1'b0;
          zustand       <= IDLE;
        end
        default: begin
          SpeicherLesen <= 1'b0;
          BefehlGeladen <= 1'b0;
          zustand       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_befehl_laden.sv
// tb_befehl_laden: self-checking bench for befehl_laden. Each fetch is described
// by its PC, number of memory wait cycles and data word; the expected bus and
// completion behaviour is derived from those numbers alone.
module tb_befehl_laden;

  localparam int unsigned T   = 4;
  localparam logic [31:0] NOP = 32'hA5A5_0013;
`ifdef BEFEHL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic        LoadBefehlSignal;
  logic [31:0] PC;
  logic [31:0] SpeicherDaten;
  logic        SpeicherBereit;
  logic [31:0] SpeicherAdresse;
  logic        SpeicherLesen;
  logic [31:0] Befehl;
  logic        BefehlGeladen;
  logic        Fehler;

  befehl_laden #(
    .TIMEOUT_ZYKLEN (T),
    .NOP_BEFEHL     (NOP)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .LoadBefehlSignal (LoadBefehlSignal),
    .PC               (PC),
    .SpeicherDaten    (SpeicherDaten),
    .SpeicherBereit   (SpeicherBereit),
    .SpeicherAdresse  (SpeicherAdresse),
    .SpeicherLesen    (SpeicherLesen),
    .Befehl           (Befehl),
    .BefehlGeladen    (BefehlGeladen),
    .Fehler           (Fehler)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] expBefehl = '0;
  logic [31:0] expAdr    = '0;
  logic        expFehler = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chkAlle(input string tag, input logic lesen, input logic geladen);
    chk({tag, ".SpeicherLesen"},   32'(SpeicherLesen), 32'(lesen));
    chk({tag, ".BefehlGeladen"},   32'(BefehlGeladen), 32'(geladen));
    chk({tag, ".SpeicherAdresse"}, SpeicherAdresse,    expAdr);
    chk({tag, ".Befehl"},          Befehl,             expBefehl);
    chk({tag, ".Fehler"},          32'(Fehler),        32'(expFehler));
  endtask

  // One fetch of k wait cycles; PC is changed to pcWaehrend while waiting
  task automatic fetch(input logic [31:0] pc, input int k, input logic [31:0] daten,
                       input logic [31:0] pcWaehrend, input bit dropLoad);
    bit abgebrochen;
    int n;
    abgebrochen = TO_EN && (k > int'(T));
    n = abgebrochen ? int'(T) + 1 : k + 1;
    LoadBefehlSignal = 1'b1;
    PC               = pc;
    SpeicherBereit   = 1'b0;
    tick();
    expAdr = pc;
    for (int i = 0; i < n; i++) begin
      chkAlle("wait", 1'b1, 1'b0);
      PC = pcWaehrend;
      if (dropLoad) LoadBefehlSignal = 1'b0;
      SpeicherBereit = !abgebrochen && (i == n - 1);
      SpeicherDaten  = SpeicherBereit ? daten : $urandom();
      tick();
    end
    if (abgebrochen) begin
      expBefehl = NOP;
      expFehler = 1'b1;
    end else begin
      expBefehl = daten;
    end
    chkAlle("done", 1'b0, 1'b1);
    LoadBefehlSignal = 1'b0;
    SpeicherBereit   = 1'($urandom_range(0, 1));
    SpeicherDaten    = $urandom();
    tick();
    chkAlle("idle", 1'b0, 1'b0);
    SpeicherBereit = 1'b0;
  endtask

  initial begin
    Reset            = 1'b0;
    LoadBefehlSignal = 1'b0;
    PC               = '0;
    SpeicherDaten    = '0;
    SpeicherBereit   = 1'b0;
    #1;
    chkAlle("reset", 1'b0, 1'b0);
    #11;
    Reset = 1'b1;
    tick();
    chkAlle("postReset", 1'b0, 1'b0);

    // Zero-wait, three-wait, PC change during WAIT, request dropped in WAIT
    fetch(32'h0000_0010, 0, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0);
    fetch(32'h0000_0014, 3, 32'hCAFE_0001, 32'h0000_0014, 1'b0);
    fetch(32'h0000_0010, 2, 32'h1234_5678, 32'h0000_0020, 1'b0);
    fetch(32'h0000_0020, 1, 32'h8765_4321, 32'h0000_0077, 1'b0);
    fetch(32'h0000_0027, 2, 32'h0BAD_F00D, 32'h0000_0027, 1'b1);

    // Ready on the terminal-count cycle must win over the timeout
    fetch(32'h0000_0028, int'(T), 32'h1111_2222, 32'h0000_0028, 1'b0);

    // Asynchronous reset in the second WAIT cycle
    LoadBefehlSignal = 1'b1;
    PC               = 32'h0000_0040;
    tick();
    LoadBefehlSignal = 1'b0;
    tick();
    #2;
    Reset = 1'b0;
    #1;
    expAdr    = '0;
    expBefehl = '0;
    expFehler = 1'b0;
    chkAlle("asyncReset", 1'b0, 1'b0);
    SpeicherBereit = 1'b1;
    tick();
    chkAlle("inReset", 1'b0, 1'b0);
    SpeicherBereit = 1'b0;
    #4;
    Reset = 1'b1;
    tick();
    chkAlle("afterReset", 1'b0, 1'b0);
    fetch(32'h0000_0030, 0, 32'h5555_AAAA, 32'h0000_0030, 1'b0);

    // Long wait: abandoned with the timeout feature, plain wait otherwise
    fetch(32'h0000_0044, 10, 32'h7777_8888, 32'h0000_0044, 1'b0);
    fetch(32'h0000_0048, 1, 32'h9999_0000, 32'h0000_0048, 1'b0);

    // Randomized fetches with idle gaps where ready must be ignored
    for (int r = 0; r < 25; r++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        SpeicherBereit = 1'($urandom_range(0, 1));
        SpeicherDaten  = $urandom();
        PC             = $urandom();
        tick();
        chkAlle("gap", 1'b0, 1'b0);
      end
      SpeicherBereit = 1'b0;
      fetch($urandom(), int'($urandom_range(0, 6)), $urandom(), $urandom(),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
